// File: rtl/res_reader_pkg.sv
// +----------------------------------------------------------------------------+
// | res_reader_pkg : shared FSM encoding and RAM read latency for res_reader   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 12
`endif

`default_nettype none

package res_reader_pkg;

  // Cycles from an issued read to its data being capturable on mem_q.
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/res_fifo.sv
// +----------------------------------------------------------------------------+
// | res_fifo : show-ahead FIFO with occupancy count and same-cycle push/pop    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module res_fifo #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int                c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w:0]      r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (c_ptr_w + 1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (c_ptr_w + 1)'(1);
      end
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/res_reader.sv
// +----------------------------------------------------------------------------+
// | res_reader : streams a run of result-RAM words out over valid/ready        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module res_reader
  import res_reader_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int TOTAL_ADDR = `TOTAL_ADDR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int                    c_cnt_w     = ADDR_WIDTH + 1;
  localparam int                    c_fcnt_w    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(TOTAL_ADDR - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_start_q;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_cnt_w-1:0]    r_issued;
  logic [c_cnt_w-1:0]    r_delivered;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [RD_LAT-1:0]     r_pipe;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [c_fcnt_w-1:0]   w_fifo_count;
  int                    w_outstanding;

  // The command is registered first; the extra IDLE cycle is where busy rises.
  assign w_accept = start && (r_state == ST_IDLE) && !r_start_q;

  // Buffered words plus reads still travelling through the RAM latency.
  always_comb begin
    w_outstanding = int'(w_fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      w_outstanding = w_outstanding + int'(r_pipe[i]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_q) begin
          w_state_next = (r_count == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        if ((r_issued < r_count) && (w_outstanding < FIFO_DEPTH)) begin
          w_issue = 1'b1;
        end
        if (w_issue && ((r_issued + c_cnt_w'(1)) == r_count)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && ((r_delivered + c_cnt_w'(1)) == r_count)) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_start_q   <= 1'b0;
      r_count     <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_addr      <= '0;
      r_pipe      <= '0;
    end else begin
      r_state <= w_state_next;
      r_pipe  <= {r_pipe[RD_LAT-2:0], w_issue};
      if (w_accept) begin
        r_start_q <= 1'b1;
        r_count   <= word_count;
        if (word_count != '0) begin
          r_addr <= base_addr;
        end
      end else if (r_start_q) begin
        r_start_q   <= 1'b0;
        r_issued    <= '0;
        r_delivered <= '0;
      end
      if (w_issue) begin
        r_issued <= r_issued + c_cnt_w'(1);
        r_addr   <= (r_addr == c_last_addr) ? '0 : r_addr + ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_delivered <= r_delivered + c_cnt_w'(1);
      end
    end
  end

  res_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (r_pipe[RD_LAT-1]),
    .push_data (mem_q),
    .pop       (w_pop),
    .head_data (out_data),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign mem_rden    = w_issue;
  assign mem_address = r_addr;
  assign out_valid   = !w_fifo_empty;
  assign w_pop       = out_valid && out_ready;
  // The head is word number r_delivered of the run.
  assign out_last    = out_valid && (r_delivered == (r_count - c_cnt_w'(1)));
  assign busy        = r_start_q || (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_FIN);

endmodule

`default_nettype wire
